alu_issue_ctrl: RTL and testbench

Shares the single 16-bit ALU between two requesters: the execute stage (port 0) and the address/PC-update unit (port 1). Uses round-robin arbitration with a valid/ready request handshake. Registers the granted operands and opcode onto the ALU inputs, waits the ALU's fixed latency, then returns the captured result and flags to the winner as a one-cycle response pulse. Sits between the decode/execute control and the ALU instance.

---
 rtl/alu_ctrl_pkg.sv | 12 +
 rtl/rr_arb2.sv | 28 ++
 rtl/alu_issue_ctrl.sv | 118 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and defaults for the ALU issue controller.
package alu_ctrl_pkg;
   localparam int W_DEF = 16;
   localparam int OPW_DEF = 6;
   localparam logic [OPW_DEF-1:0] NOP_OP_DEF = 6'b111111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last winner.
module rr_arb2 (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_upd,
   output logic o_gnt0,
   output logic o_gnt1,
   output logic o_idx
);
   logic r_last;
   logic w_pick1;

   // On a tie the requester that did not win last time goes first
   assign w_pick1 = i_valid1 & (~i_valid0 | ~r_last);
   assign o_gnt1  = i_en & w_pick1;
   assign o_gnt0  = i_en & i_valid0 & ~w_pick1;
   assign o_idx   = w_pick1;

   always_ff @(posedge clk) begin
      if (reset)
         r_last <= 1'b1;
      else if (i_upd)
         r_last <= w_pick1;
   end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Arbitrates two requesters onto one ALU and returns the result as a pulse.
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int OPW = OPW_DEF,
   parameter int ALU_LAT = 1,
   parameter int CNT_W = 4,
   parameter logic [OPW-1:0] NOP_OP = OPW'(NOP_OP_DEF)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [OPW-1:0] req0_op,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [OPW-1:0] req1_op,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic [OPW-1:0] alu_op,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   input  logic [W-1:0]   alu_ans,
   input  logic [1:0]     alu_flag,
   output logic           rsp0_valid,
   output logic           rsp1_valid,
   output logic [W-1:0]   rsp_data,
   output logic [1:0]     rsp_flag,
   output logic           busy
);
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_gnt;
   logic [OPW-1:0]   r_alu_op;
   logic [W-1:0]     r_alu_a;
   logic [W-1:0]     r_alu_b;
   logic             r_rsp0;
   logic             r_rsp1;
   logic [W-1:0]     r_rsp_data;
   logic [1:0]       r_rsp_flag;

   logic w_idle;
   logic w_hs;
   logic w_idx;

   assign w_idle = (r_state == S_IDLE);

   // Reset suppresses ready so no handshake can coincide with it
   rr_arb2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .i_en     (w_idle & ~reset),
      .i_valid0 (req0_valid),
      .i_valid1 (req1_valid),
      .i_upd    (w_hs),
      .o_gnt0   (req0_ready),
      .o_gnt1   (req1_ready),
      .o_idx    (w_idx)
   );

   assign w_hs = req0_ready | req1_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_gnt      <= 1'b0;
         r_alu_op   <= NOP_OP;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_rsp0     <= 1'b0;
         r_rsp1     <= 1'b0;
         r_rsp_data <= '0;
         r_rsp_flag <= '0;
      end else begin
         r_rsp0 <= 1'b0;
         r_rsp1 <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_alu_op <= w_idx ? req1_op : req0_op;
                  r_alu_a  <= w_idx ? req1_a : req0_a;
                  r_alu_b  <= w_idx ? req1_b : req0_b;
                  r_cnt    <= CNT_W'(ALU_LAT);
                  r_gnt    <= w_idx;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_rsp_data <= alu_ans;
                  r_rsp_flag <= alu_flag;
                  r_alu_op   <= NOP_OP;
                  r_rsp0     <= ~r_gnt;
                  r_rsp1     <= r_gnt;
                  r_state    <= S_RESP;
               end
            end
            S_RESP: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign alu_op     = r_alu_op;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign rsp0_valid = r_rsp0;
   assign rsp1_valid = r_rsp1;
   assign rsp_data   = r_rsp_data;
   assign rsp_flag   = r_rsp_flag;
   assign busy       = ~w_idle;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: vector table, directed corners, random vs model.
module tb_alu_issue_ctrl;
   localparam int LAT = 1;
   localparam logic [5:0] NOP = 6'b111111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic v0, v1, rdy0, rdy1;
   logic [5:0] op0, op1, aop;
   logic [15:0] a0, b0, a1, b1, aa, ab, ans, rdata;
   logic [1:0] aflag, rflag;
   logic rs0, rs1, bsy;
   logic [16:0] sum;

   alu_issue_ctrl #(.ALU_LAT(1)) dut (
      .clk(clk), .reset(rst),
      .req0_valid(v0), .req0_ready(rdy0), .req0_op(op0),
      .req0_a(a0), .req0_b(b0),
      .req1_valid(v1), .req1_ready(rdy1), .req1_op(op1),
      .req1_a(a1), .req1_b(b1),
      .alu_op(aop), .alu_a(aa), .alu_b(ab),
      .alu_ans(ans), .alu_flag(aflag),
      .rsp0_valid(rs0), .rsp1_valid(rs1),
      .rsp_data(rdata), .rsp_flag(rflag), .busy(bsy)
   );

   assign sum = {1'b0, aa} + {1'b0, ab};
   always_ff @(posedge clk) begin
      if (rst) begin
         ans <= '0;
         aflag <= '0;
      end else begin
         ans <= sum[15:0];
         aflag <= {sum[16], sum[15:0] == 16'h0};
      end
   end

   logic d3_v0, d3_r0, d3_r1, d3_s0, d3_s1, d3_bsy;
   logic [5:0] d3_aop;
   logic [15:0] d3_a0, d3_b0, d3_aa, d3_ab, d3_ans, d3_rdata;
   logic [1:0] d3_aflag, d3_rflag;
   logic [16:0] d3_sum;

   alu_issue_ctrl #(.ALU_LAT(3)) dut3 (
      .clk(clk), .reset(rst),
      .req0_valid(d3_v0), .req0_ready(d3_r0), .req0_op(6'h01),
      .req0_a(d3_a0), .req0_b(d3_b0),
      .req1_valid(1'b0), .req1_ready(d3_r1), .req1_op(6'h00),
      .req1_a(16'h0), .req1_b(16'h0),
      .alu_op(d3_aop), .alu_a(d3_aa), .alu_b(d3_ab),
      .alu_ans(d3_ans), .alu_flag(d3_aflag),
      .rsp0_valid(d3_s0), .rsp1_valid(d3_s1),
      .rsp_data(d3_rdata), .rsp_flag(d3_rflag), .busy(d3_bsy)
   );

   assign d3_sum = {1'b0, d3_aa} + {1'b0, d3_ab};
   always_ff @(posedge clk) begin
      if (rst) begin
         d3_ans <= '0;
         d3_aflag <= '0;
      end else begin
         d3_ans <= d3_sum[15:0];
         d3_aflag <= {d3_sum[16], d3_sum[15:0] == 16'h0};
      end
   end

   int total = 0;
   int bad = 0;
   int c;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h cyc=%0d", n, act, exp, c);
      end
   endtask

   // Transaction-level reference: each accepted op owns the ALU for
   // LAT+3 cycles and answers LAT+2 cycles after acceptance.
   int free_at, resp_cyc, resp_who, rr_last, hs_c;
   logic [15:0] resp_val, cur_d, l_a, l_b;
   logic [1:0] resp_f, cur_f;
   logic [5:0] l_op;
   bit fresh;

   task automatic model_reset();
      free_at = c + 1;
      resp_cyc = -1;
      cur_d = '0;
      cur_f = '0;
      rr_last = 1;
      fresh = 1;
      hs_c = -100;
   endtask

   task automatic model();
      int g;
      bit idle;
      logic [16:0] s;
      if (c == resp_cyc) begin
         cur_d = resp_val;
         cur_f = resp_f;
      end
      idle = (c >= free_at);
      g = -1;
      if (idle) begin
         if (v0 && v1) g = 1 - rr_last;
         else if (v0) g = 0;
         else if (v1) g = 1;
      end
      chk("ready0", rdy0, !rst && g == 0);
      chk("ready1", rdy1, !rst && g == 1);
      chk("rsp0", rs0, c == resp_cyc && resp_who == 0);
      chk("rsp1", rs1, c == resp_cyc && resp_who == 1);
      chk("busy", bsy, !idle);
      chk("rsp_data", rdata, cur_d);
      chk("rsp_flag", rflag, cur_f);
      if (idle) chk("alu_op_idle", aop, NOP);
      if (fresh) begin
         chk("alu_a_rst", aa, 0);
         chk("alu_b_rst", ab, 0);
      end
      if (!idle && c <= hs_c + LAT + 1) begin
         chk("alu_op", aop, l_op);
         chk("alu_a", aa, l_a);
         chk("alu_b", ab, l_b);
      end
      if (rst) begin
         model_reset();
      end else if (g >= 0) begin
         l_op = g ? op1 : op0;
         l_a = g ? a1 : a0;
         l_b = g ? b1 : b0;
         s = {1'b0, l_a} + {1'b0, l_b};
         resp_val = s[15:0];
         resp_f = {s[16], s[15:0] == 16'h0};
         resp_cyc = c + LAT + 2;
         free_at = c + LAT + 3;
         resp_who = g;
         rr_last = g;
         fresh = 0;
         hs_c = c;
      end
      c++;
   endtask

   task automatic step();
      #1;
      model();
      @(negedge clk);
   endtask

   typedef struct {
      logic [2:0] ctl;
      logic [4:0] ex;
      logic ca;
      logic [5:0] eop;
      logic [15:0] ea, eb, ed;
      logic [1:0] ef;
   } vec_t;

   vec_t tv[20];
   int nr, ns;

   initial begin
      tv[0]  = '{3'b000, 5'b00000, 1'b1, 6'h3F, 16'h0, 16'h0, 16'h0, 2'b00};
      tv[1]  = '{3'b010, 5'b10000, 1'b1, 6'h3F, 16'h0, 16'h0, 16'h0, 2'b00};
      tv[2]  = '{3'b000, 5'b00001, 1'b1, 6'h01, 16'h4000, 16'hC000,
                 16'h0, 2'b00};
      tv[3]  = tv[2];
      tv[4]  = '{3'b000, 5'b00101, 1'b0, 6'h3F, 16'h0, 16'h0, 16'h0, 2'b11};
      tv[5]  = '{3'b000, 5'b00000, 1'b0, 6'h3F, 16'h0, 16'h0, 16'h0, 2'b11};
      tv[6]  = '{3'b111, 5'b00000, 1'b0, 6'h3F, 16'h0, 16'h0, 16'h0, 2'b00};
      tv[7]  = '{3'b011, 5'b10000, 1'b1, 6'h3F, 16'h0, 16'h0, 16'h0, 2'b00};
      tv[8]  = '{3'b011, 5'b00001, 1'b1, 6'h01, 16'h4000, 16'hC000,
                 16'h0, 2'b00};
      tv[9]  = tv[8];
      tv[10] = '{3'b011, 5'b00101, 1'b0, 6'h3F, 16'h0, 16'h0, 16'h0, 2'b11};
      tv[11] = '{3'b011, 5'b01000, 1'b0, 6'h3F, 16'h0, 16'h0, 16'h0, 2'b11};
      tv[12] = '{3'b011, 5'b00001, 1'b1, 6'h03, 16'h0010, 16'h0020,
                 16'h0, 2'b11};
      tv[13] = tv[12];
      tv[14] = '{3'b011, 5'b00011, 1'b0, 6'h3F, 16'h0, 16'h0,
                 16'h0030, 2'b00};
      tv[15] = '{3'b011, 5'b10000, 1'b0, 6'h3F, 16'h0, 16'h0,
                 16'h0030, 2'b00};
      tv[16] = '{3'b011, 5'b00001, 1'b1, 6'h01, 16'h4000, 16'hC000,
                 16'h0030, 2'b00};
      tv[17] = tv[16];
      tv[18] = '{3'b000, 5'b00101, 1'b0, 6'h3F, 16'h0, 16'h0, 16'h0, 2'b11};
      tv[19] = '{3'b000, 5'b00000, 1'b0, 6'h3F, 16'h0, 16'h0, 16'h0, 2'b11};

      rst = 1'b1;
      {v0, v1} = 2'b00;
      op0 = 6'h01; a0 = 16'h4000; b0 = 16'hC000;
      op1 = 6'h03; a1 = 16'h0010; b1 = 16'h0020;
      d3_v0 = 1'b0; d3_a0 = 16'h0; d3_b0 = 16'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      c = 0;
      model_reset();
      free_at = 0;

      for (int i = 0; i < 20; i++) begin
         {rst, v0, v1} = tv[i].ctl;
         #1;
         if (!tv[i].ctl[2]) begin
            chk("tbl_ready0", rdy0, tv[i].ex[4]);
            chk("tbl_ready1", rdy1, tv[i].ex[3]);
            chk("tbl_rsp0", rs0, tv[i].ex[2]);
            chk("tbl_rsp1", rs1, tv[i].ex[1]);
            chk("tbl_busy", bsy, tv[i].ex[0]);
            chk("tbl_data", rdata, tv[i].ed);
            chk("tbl_flag", rflag, tv[i].ef);
            if (tv[i].ca) begin
               chk("tbl_alu_op", aop, tv[i].eop);
               chk("tbl_alu_a", aa, tv[i].ea);
               chk("tbl_alu_b", ab, tv[i].eb);
            end
         end
         step();
      end

      // req1 alone, held valid: accepted every fourth cycle
      rst = 1'b0;
      op1 = 6'h04; a1 = 16'h0003; b1 = 16'h0004;
      v0 = 1'b0; v1 = 1'b1;
      nr = 0; ns = 0;
      for (int k = 0; k < 12; k++) begin
         #1;
         nr += int'(rdy1);
         ns += int'(rs1);
         if (rs1) begin
            chk("b2b_data", rdata, 16'h0007);
            chk("b2b_flag", rflag, 2'b00);
         end
         chk("b2b_no_rsp0", rs0, 0);
         step();
      end
      chk("b2b_ready_cnt", nr, 3);
      chk("b2b_rsp_cnt", ns, 3);
      v1 = 1'b0;
      step();

      // reset while waiting on the ALU
      op0 = 6'h05; a0 = 16'h1234; b0 = 16'h0001;
      v0 = 1'b1;
      #1 chk("rw_ready0", rdy0, 1);
      step();
      v0 = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("rw_alu_op", aop, NOP);
      chk("rw_alu_a", aa, 0);
      chk("rw_data", rdata, 0);
      chk("rw_busy", bsy, 0);
      repeat (3) step();
      a0 = 16'h0002; b0 = 16'h0003;
      v0 = 1'b1;
      #1 chk("rw_again_ready0", rdy0, 1);
      step();
      v0 = 1'b0;
      repeat (2) step();
      #1;
      chk("rw_again_rsp0", rs0, 1);
      chk("rw_again_data", rdata, 16'h0005);
      step();

      // request withdrawn while busy leaves arbitration history alone
      v0 = 1'b1;
      step();
      v0 = 1'b0; v1 = 1'b1;
      #1 chk("wd_ready1", rdy1, 0);
      step();
      v1 = 1'b0;
      repeat (2) step();
      {v0, v1} = 2'b11;
      #1;
      chk("wd_tie_ready1", rdy1, 1);
      chk("wd_tie_ready0", rdy0, 0);
      step();
      {v0, v1} = 2'b00;
      repeat (3) step();

      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(0, 49) == 0);
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         op0 = 6'($urandom); a0 = 16'($urandom); b0 = 16'($urandom);
         op1 = 6'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
         step();
      end
      rst = 1'b0;
      {v0, v1} = 2'b00;
      repeat (6) step();

      // longer ALU latency instance
      d3_v0 = 1'b1; d3_a0 = 16'h4000; d3_b0 = 16'hC000;
      #1 chk("l3_ready0", d3_r0, 1);
      @(negedge clk);
      d3_v0 = 1'b0; d3_a0 = 16'h1111; d3_b0 = 16'h2222;
      for (int k = 1; k <= 6; k++) begin
         #1;
         chk("l3_rsp0", d3_s0, k == 5);
         chk("l3_busy", d3_bsy, k <= 5);
         if (k <= 4) begin
            chk("l3_alu_a", d3_aa, 16'h4000);
            chk("l3_alu_op", d3_aop, 6'h01);
         end
         if (k == 5) begin
            chk("l3_data", d3_rdata, 16'h0000);
            chk("l3_flag", d3_rflag, 2'b11);
         end
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
